// File: rtl/pong_sound_pkg.sv
// Shared definitions for the Pong sound sequencer: effect codes, note table
// constants and the default tick divider.
package pong_sound_pkg;

  // Codes are ordered by priority so a plain magnitude compare decides preemption.
  typedef enum logic [1:0] {
    EFF_NONE   = 2'd0,
    EFF_WALL   = 2'd1,
    EFF_PADDLE = 2'd2,
    EFF_SCORE  = 2'd3
  } effect_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

  localparam int unsigned DEFAULT_TICK_DIVIDE = 50000;

  localparam int unsigned SCORE_HALF0  = 47801;
  localparam int unsigned SCORE_HALF1  = 37936;
  localparam int unsigned SCORE_HALF2  = 31888;
  localparam int unsigned PADDLE_HALF0 = 56818;
  localparam int unsigned WALL_HALF0   = 113636;

  localparam logic [7:0] SCORE_DUR  = 8'd80;
  localparam logic [7:0] PADDLE_DUR = 8'd50;
  localparam logic [7:0] WALL_DUR   = 8'd30;

  function automatic logic [1:0] note_count(input effect_t eff);
    case (eff)
      EFF_SCORE:  note_count = 2'd3;
      EFF_PADDLE: note_count = 2'd1;
      EFF_WALL:   note_count = 2'd1;
      default:    note_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Duration prescaler: counts 0..TickDivide-1, flags the wrap cycle with Tick.
module ms_tick
  import pong_sound_pkg::*;
#(
  parameter int unsigned TickDivide = DEFAULT_TICK_DIVIDE
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned CountBits = $clog2(TickDivide);
  localparam logic [CountBits-1:0] LastCount = CountBits'(TickDivide - 1);

  logic [CountBits-1:0] count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (Clear || count == LastCount) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign Tick = (count == LastCount);

endmodule

// File: rtl/pong_sound_sequencer.sv
// Plays fixed tone effects for Pong events by stepping through a small note
// table and driving the tone generator's half-period input.
module pong_sound_sequencer
  import pong_sound_pkg::*;
#(
  parameter int unsigned NumberOfBits = 20,
  parameter int unsigned TickDivide   = DEFAULT_TICK_DIVIDE
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    PaddleHit,
  input  logic                    WallHit,
  input  logic                    Score,
  input  logic                    Mute,
  output logic [NumberOfBits-1:0] HalfPeriod,
  output logic                    Busy
);

  seq_state_t state_q, state_d;
  effect_t    effect_q, effect_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] remaining_q, remaining_d;
  logic [NumberOfBits-1:0] half_d;
  logic       busy_d;

  logic    tick, clear;
  effect_t ev, lk_eff;
  logic [1:0] lk_idx;
  logic [NumberOfBits-1:0] lk_half;
  logic [7:0] lk_dur;
  logic    accept, note_end, has_next;

  ms_tick #(.TickDivide(TickDivide)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (clear),
    .Tick  (tick)
  );

  always_comb begin
    if (Score)          ev = EFF_SCORE;
    else if (PaddleHit) ev = EFF_PADDLE;
    else if (WallHit)   ev = EFF_WALL;
    else                ev = EFF_NONE;
  end

  assign accept   = !Mute && (ev != EFF_NONE) && (state_q == IDLE || ev >= effect_q);
  assign note_end = (state_q == PLAY) && tick && (remaining_q == 8'd1);
  assign has_next = (idx_q + 2'd1) < note_count(effect_q);
  // One lookup serves both a fresh effect (note 0) and the next note of the current one.
  assign lk_eff   = accept ? ev : effect_q;
  assign lk_idx   = accept ? 2'd0 : idx_q + 2'd1;

  always_comb begin
    lk_half = '0;
    lk_dur  = '0;
    case (lk_eff)
      EFF_SCORE: begin
        lk_dur = SCORE_DUR;
        case (lk_idx)
          2'd0:    lk_half = NumberOfBits'(SCORE_HALF0);
          2'd1:    lk_half = NumberOfBits'(SCORE_HALF1);
          2'd2:    lk_half = NumberOfBits'(SCORE_HALF2);
          default: lk_half = '0;
        endcase
      end
      EFF_PADDLE: begin
        lk_dur  = PADDLE_DUR;
        lk_half = NumberOfBits'(PADDLE_HALF0);
      end
      EFF_WALL: begin
        lk_dur  = WALL_DUR;
        lk_half = NumberOfBits'(WALL_HALF0);
      end
      default: begin
        lk_dur  = '0;
        lk_half = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    effect_d    = effect_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    half_d      = HalfPeriod;
    busy_d      = Busy;
    clear       = 1'b0;
    if (Mute || (note_end && !has_next && !accept)) begin
      state_d     = IDLE;
      effect_d    = EFF_NONE;
      idx_d       = '0;
      remaining_d = '0;
      half_d      = '0;
      busy_d      = 1'b0;
      clear       = 1'b1;
    end else if (accept || note_end) begin
      state_d     = PLAY;
      effect_d    = lk_eff;
      idx_d       = lk_idx;
      remaining_d = lk_dur;
      half_d      = lk_half;
      busy_d      = 1'b1;
      clear       = 1'b1;
    end else if (state_q == PLAY && tick) begin
      remaining_d = remaining_q - 8'd1;
    end else if (state_q == IDLE) begin
      clear = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      effect_q    <= EFF_NONE;
      idx_q       <= '0;
      remaining_q <= '0;
      HalfPeriod  <= '0;
      Busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      effect_q    <= effect_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      HalfPeriod  <= half_d;
      Busy        <= busy_d;
    end
  end

endmodule

// File: doc/pong_sound_sequencer.md
# pong_sound_sequencer

Converts Pong game events (paddle hit, wall bounce, score) into timed sequences of tone half-periods. Drives the half-period input of the downstream square-wave tone generator: non-zero selects a tone, zero means silence. Each event plays a fixed effect of one to three notes from an internal note table, with per-note durations in millisecond ticks and a fixed priority between effects.

## Interface
Parameters:
- NumberOfBits, 20: width of HalfPeriod; must match the tone generator.
- TickDivide, 50000: Clock cycles per duration tick (1 ms at 50 MHz). Must be ≥ 2.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low; low forces the idle state immediately.
- PaddleHit  in  1  single-cycle event pulse.
- WallHit  in  1  single-cycle event pulse.
- Score  in  1  single-cycle event pulse.
- Mute  in  1  level; high blocks new effects and aborts any playing effect.
- HalfPeriod  out  NumberOfBits  registered tone half-period to the tone generator; 0 = silence.
- Busy  out  1  registered; high while an effect is playing.

## Operation
- States: IDLE, PLAY.
- Effects, with half-period values at 50 MHz and durations in ticks:
  - Score (priority 2): 47801/80, 37936/80, 31888/80.
  - PaddleHit (priority 1): 56818/50.
  - WallHit (priority 0): 113636/30.
- IDLE: HalfPeriod=0, Busy=0.
- Event accepted (Mute low):
  - Load the effect's note 0: HalfPeriod ← its value; remaining ticks ← its duration; tick prescaler ← 0; note index ← 0; Busy ← 1.
  - Enter PLAY.
- PLAY:
  - Prescaler counts 0..TickDivide−1 and wraps.
  - On each wrap, remaining ticks decrements.
  - When a wrap takes remaining ticks from 1 to 0:
    - If a next note exists, load it (prescaler restarts at 0).
    - Otherwise go to IDLE with HalfPeriod←0 and Busy←0.
- Simultaneous events in the same cycle: the highest priority wins; the others are dropped.
- Event during PLAY:
  - Priority ≥ the current effect's priority: the new effect restarts from its note 0 on that edge.
  - Lower priority: ignored, with no queueing.
- Mute high at any edge:
  - Next state is IDLE, HalfPeriod←0, Busy←0.
  - Events seen in the same cycle are ignored.
- Reset low: the state machine, counters and both outputs go to 0/IDLE without waiting for a clock edge. No event is accepted while Reset is low.
- Arithmetic: prescaler width is clog2(TickDivide) and duration width is 8 bits; neither may wrap past its limit.

## Timing
- Latency: an event high at edge k gives HalfPeriod = note 0 and Busy=1 after edge k.
- Each note lasts exactly duration×TickDivide cycles.
- The next note's value appears on the same edge that ends the previous note, with no silent gap cycle.
- Last note: HalfPeriod=0 and Busy=0 after edge k + (sum of durations)×TickDivide.
- An event held high for N cycles restarts the effect on each of those N edges. The effect length is therefore counted from the last high cycle.
- Mute abort takes effect on the first edge where Mute is sampled high.

## Structure
- Shared package pong_sound_pkg holds:
  - effect codes and priorities (NONE, WALL, PADDLE, SCORE);
  - the note table constants (half-period, duration, note count per effect);
  - the default TickDivide.
- One sub-module, ms_tick: the prescaler. It has a synchronous clear, issues a one-cycle tick on wrap, and is parameterised by TickDivide.
- The sequencer FSM and the note-table lookup (a case on effect and note index) stay in the top module.

## Test plan
All scenarios use TickDivide=4.
- Reset low mid-PLAY of Score → HalfPeriod=0 and Busy=0 at once, with no clock edge needed. After release, stays idle until the next event.
- PaddleHit pulse at edge k → HalfPeriod=56818 and Busy=1 after edge k. HalfPeriod=0 and Busy=0 after edge k+200.
- Score pulse → 47801 for 320 cycles, then 37936 for 320 cycles, then 31888 for 320 cycles, then 0. Busy falls at cycle 960 with no gap between notes.
- PaddleHit and WallHit in the same cycle → 56818 is played. WallHit 10 cycles into a PaddleHit → ignored, PaddleHit ends on schedule. Score 10 cycles into a PaddleHit → 47801 on the next edge.
- PaddleHit 100 cycles into a PaddleHit → restart; end moves to 200 cycles after the second pulse.
- Mute raised mid-Score → HalfPeriod=0 after the next edge. PaddleHit with Mute high → no response.
